pipe_skid_reg: RTL

Parametrised pipeline-boundary register for the five-stage core, e.g. the M/WB boundary. It replaces the plain stall-gated flop bank with a two-entry skid buffer.
- Carries LANES data words, a register-file write destination and a write enable.
- Uses a valid/ready handshake with a registered-path ready, plus a synchronous flush for bubble insertion.
- Preserves order and never drops or duplicates an accepted transfer, except on flush.

---
 rtl/pipe_skid_reg.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// +----------------------------------------------------------------------------+
// | pipe_skid_reg : two-entry skid buffer at a pipeline boundary (valid/ready) |
// | Optional perf counters: define PIPE_SKID_PERF_EN.          Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_skid_reg #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int WD_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [WD_W-1:0]           in_wd,
  input  logic                      in_wen,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [WD_W-1:0]           out_wd,
  output logic                      out_wen
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [15:0]               perf_stall_cnt,
  output logic [15:0]               perf_flush_cnt
`endif
);

  localparam int PAY_W = LANES * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  logic              main_valid_q, main_valid_d;
  logic [PAY_W-1:0]  main_data_q,  main_data_d;
  logic [WD_W-1:0]   main_wd_q,    main_wd_d;
  logic              main_wen_q,   main_wen_d;

  logic              skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0]  skid_data_q,  skid_data_d;
  logic [WD_W-1:0]   skid_wd_q,    skid_wd_d;
  logic              skid_wen_q,   skid_wen_d;

  state_e            state;
  logic              acc;
  logic              tak;

  // Ready comes only from registered state so no combinational path from out_ready.
  assign in_ready  = rst_n & ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_wd    = main_wd_q;
  assign out_wen   = main_wen_q & main_valid_q;

  assign acc = in_valid & in_ready;
  assign tak = main_valid_q & out_ready;

  always_comb begin
    state = EMPTY;
    if (skid_valid_q) begin
      state = FULL;
    end else if (main_valid_q) begin
      state = ONE;
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_wd_d    = main_wd_q;
    main_wen_d   = main_wen_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_wd_d    = skid_wd_q;
    skid_wen_d   = skid_wen_q;

    if (flush) begin
      // Payload regs are left alone; the valid gate hides stale contents.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_wd_d    = in_wd;
            main_wen_d   = in_wen;
          end
        end
        ONE: begin
          if (acc && tak) begin
            main_data_d  = in_data;
            main_wd_d    = in_wd;
            main_wen_d   = in_wen;
          end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_wd_d    = in_wd;
            skid_wen_d   = in_wen;
          end else if (tak) begin
            main_valid_d = 1'b0;
          end
        end
        FULL: begin
          if (tak) begin
            main_data_d  = skid_data_q;
            main_wd_d    = skid_wd_q;
            main_wen_d   = skid_wen_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_valid_d = main_valid_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_wd_q    <= '0;
      main_wen_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_wd_q    <= '0;
      skid_wen_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_wd_q    <= main_wd_d;
      main_wen_q   <= main_wen_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_wd_q    <= skid_wd_d;
      skid_wen_q   <= skid_wen_d;
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush && (main_valid_q || skid_valid_q) && flush_cnt_q != 16'hFFFF) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire
